// File: rtl/uart_rx_sipo.sv
// Oversampling UART frame receiver: start/false-start detection, DATA_BITS deserialise, optional parity.
// Word appears one cycle after the last stop sample; it is held under valid/ready, and frames arriving while it is held are dropped and flagged as overrun.
module uart_rx_sipo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int LSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 fe_q, fe_d, pe_q, pe_d;
  logic                 armed_q, armed_d;
  logic                 rx_meta, rx_s;
  logic                 deliver;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    armed_d = armed_q;
    deliver = 1'b0;
    case (state_q)
      IDLE: begin
        // a line held low after a frame must go high before it can start another
        armed_d = armed_q | rx_s;
        if (armed_q && !rx_s) begin
          state_d = START;
          tick_d  = '0;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (tick_q == TICK_MID) begin
          tick_d = '0;
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      DATA: begin
        if (tick_q == TICK_END) begin
          tick_d = '0;
          if (LSB_FIRST != 0) shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          else                shreg_d = {shreg_q[DATA_BITS-2:0], rx_s};
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      PARITY: begin
        if (tick_q == TICK_END) begin
          tick_d  = '0;
          pe_d    = ((^shreg_q) ^ rx_s) != (PARITY_ODD != 0);
          state_d = STOP;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      STOP: begin
        // bit_q counts stop samples taken; reaching STOP_BITS means the frame is complete
        if (bit_q == BW'(STOP_BITS)) begin
          deliver = 1'b1;
          bit_d   = '0;
          state_d = IDLE;
        end else if (tick_q == TICK_END) begin
          tick_d = '0;
          bit_d  = bit_q + BW'(1);
          if (!rx_s) fe_d = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (deliver && (!data_valid || data_ready)) begin
        data_out   <= shreg_q;
        frame_err  <= fe_q;
        parity_err <= pe_q;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        frame_err  <= 1'b0;
        parity_err <= 1'b0;
      end
      if (deliver && data_valid && !data_ready) overrun <= 1'b1;
      else if (data_valid && data_ready)        overrun <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Directed bench for uart_rx_sipo: default 8N1, even-parity and 7-bit MSB-first/2-stop instances.
module tb_uart_rx_sipo;

  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0, rdy2 = 1'b0;

  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic v0, fe0, pe0, ov0, busy0;
  logic v1, fe1, pe1, ov1, busy1;
  logic v2, fe2, pe2, ov2, busy2;

  int checks = 0;
  int failures = 0;

  uart_rx_sipo u_dflt (
    .clk(clk), .reset_n(reset_n), .rx_in(rx0), .data_out(d0), .data_valid(v0),
    .data_ready(rdy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(busy0)
  );

  uart_rx_sipo #(.PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .reset_n(reset_n), .rx_in(rx1), .data_out(d1), .data_valid(v1),
    .data_ready(rdy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(busy1)
  );

  uart_rx_sipo #(.DATA_BITS(7), .LSB_FIRST(0), .STOP_BITS(2)) u_msb (
    .clk(clk), .reset_n(reset_n), .rx_in(rx2), .data_out(d2), .data_valid(v2),
    .data_ready(rdy2), .frame_err(fe2), .parity_err(pe2), .overrun(ov2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // seq[0] goes on the line first; each bit is held one bit period
  task automatic send_bits(input int sel, input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      case (sel)
        0:       rx0 = seq[i];
        1:       rx1 = seq[i];
        default: rx2 = seq[i];
      endcase
      repeat (OS) @(posedge clk);
      #1;
    end
  endtask

  task automatic accept(input int sel);
    case (sel)
      0:       rdy0 = 1'b1;
      1:       rdy1 = 1'b1;
      default: rdy2 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    rdy2 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(v0), 0);
    check("rst_data", 32'(d0), 0);
    check("rst_flags", 32'({fe0, pe0, ov0}), 0);
    check("rst_busy", 32'(busy0), 0);
    check("rst_msb_data", 32'(d2), 0);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 frame, bits 1,1,1,0,0,0,0,1 LSB first
    send_bits(0, {1'b1, 8'h87, 1'b0}, 10);
    check("t1_valid", 32'(v0), 1);
    check("t1_data", 32'(d0), 'h87);
    check("t1_fe", 32'(fe0), 0);
    check("t1_pe", 32'(pe0), 0);
    check("t1_busy", 32'(busy0), 0);
    rdy0 = 1'b1;
    @(posedge clk);
    #1;
    check("t1_accept_valid", 32'(v0), 0);
    rdy0 = 1'b0;

    // glitch shorter than half a bit is rejected
    rx0 = 1'b0;
    repeat (OS / 4) @(posedge clk);
    #1;
    rx0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t2_busy_glitch", 32'(busy0), 1);
    repeat (20) @(posedge clk);
    #1;
    check("t2_busy_idle", 32'(busy0), 0);
    check("t2_no_valid", 32'(v0), 0);
    send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
    check("t2_valid", 32'(v0), 1);
    check("t2_data", 32'(d0), 'hA5);
    accept(0);
    check("t2_accept_valid", 32'(v0), 0);

    // even parity: 8'h03 with parity 1 is wrong, with parity 0 is right
    send_bits(1, {1'b1, 1'b1, 8'h03, 1'b0}, 11);
    check("t3_valid", 32'(v1), 1);
    check("t3_data", 32'(d1), 'h03);
    check("t3_pe_bad", 32'(pe1), 1);
    check("t3_fe", 32'(fe1), 0);
    accept(1);
    check("t3_pe_clear", 32'(pe1), 0);
    send_bits(1, {1'b1, 1'b0, 8'h03, 1'b0}, 11);
    check("t3_data_ok", 32'(d1), 'h03);
    check("t3_pe_ok", 32'(pe1), 0);
    check("t3_valid_ok", 32'(v1), 1);
    accept(1);

    // bad stop bit then a break: one frame only, no retrigger
    send_bits(0, {1'b0, 8'h55, 1'b0}, 10);
    repeat (3 * OS) @(posedge clk);
    #1;
    check("t4_valid", 32'(v0), 1);
    check("t4_data", 32'(d0), 'h55);
    check("t4_fe", 32'(fe0), 1);
    check("t4_break_busy", 32'(busy0), 0);
    accept(0);
    check("t4_fe_clear", 32'(fe0), 0);
    check("t4_accept_valid", 32'(v0), 0);
    rx0 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_bits(0, {1'b1, 8'h5A, 1'b0}, 10);
    check("t4_next_data", 32'(d0), 'h5A);
    check("t4_next_fe", 32'(fe0), 0);
    accept(0);

    // back-to-back with no consumer: second frame dropped
    send_bits(0, {1'b1, 8'h11, 1'b0}, 10);
    send_bits(0, {1'b1, 8'h22, 1'b0}, 10);
    check("t5_held_data", 32'(d0), 'h11);
    check("t5_valid", 32'(v0), 1);
    check("t5_overrun", 32'(ov0), 1);
    accept(0);
    check("t5_ovr_clear", 32'(ov0), 0);
    check("t5_accept_valid", 32'(v0), 0);

    // ready coincides with delivery: old word accepted and new one loaded same edge
    send_bits(0, {1'b1, 8'h44, 1'b0}, 10);
    check("t5_held44", 32'(d0), 'h44);
    fork
      send_bits(0, {1'b1, 8'h33, 1'b0}, 10);
      begin
        repeat (155) @(posedge clk);
        #1;
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
      end
    join
    check("t5_swap_data", 32'(d0), 'h33);
    check("t5_swap_valid", 32'(v0), 1);
    check("t5_swap_ovr", 32'(ov0), 0);
    accept(0);
    check("t5_final_valid", 32'(v0), 0);

    // 7 data bits MSB first, two stop bits: 1,0,1,1,0,0,1 -> 7'h59
    send_bits(2, 16'b11_1001_1010, 10);
    check("t6_valid", 32'(v2), 1);
    check("t6_data", 32'(d2), 'h59);
    check("t6_fe", 32'(fe2), 0);
    rx2 = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t6_busy_mid", 32'(busy2), 1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_data", 32'(d2), 0);
    check("t6_rst_valid", 32'(v2), 0);
    check("t6_rst_busy", 32'(busy2), 0);
    check("t6_rst_flags", 32'({fe2, pe2, ov2}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Parametrised serial-in/parallel-out frame receiver, the successor to the fixed 8-bit, externally clocked SIPO used in the serial link. It runs on the system clock and oversamples an asynchronous serial line. It detects start bits and rejects false starts, deserialises a configurable number of data bits, and optionally checks parity. Each word is presented through a valid/ready handshake with framing, parity and overrun status, and it feeds the parallel side of the serial-communication path.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
OVERSAMPLE, 16, clk cycles per bit period (even, >=4)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
STOP_BITS, 1, stop bits per frame (1 or 2)
LSB_FIRST, 1, 1 = first data bit received is data_out[0]; 0 = first is data_out[DATA_BITS-1]

Ports:
clk  input  1  system clock; all state on posedge
reset_n  input  1  asynchronous active-low reset
rx_in  input  1  asynchronous serial line, idle high
data_out  output  DATA_BITS  received word, stable while data_valid=1
data_valid  output  1  word available
data_ready  input  1  consumer accepts the word when data_valid & data_ready on a clk edge
frame_err  output  1  a stop bit was sampled 0 for the held word
parity_err  output  1  parity mismatch for the held word (always 0 if PARITY_EN=0)
overrun  output  1  sticky: one or more frames were dropped because data_valid was not consumed
busy  output  1  receiver is not in IDLE

Behaviour:
- Reset (reset_n=0, asynchronous): 2-flop synchroniser = 1, state = IDLE, counters = 0, data_out = 0, data_valid = 0, frame_err = 0, parity_err = 0, overrun = 0, busy = 0.
- rx_in passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, so there is 2 cycles of input latency.
- States: IDLE, START, DATA, PARITY, STOP. There is one tick counter (0..OVERSAMPLE-1) and one bit counter.
- IDLE:
  - Armed only after rx_s=1 has been seen for at least 1 cycle. This holds after reset and after any frame, so a held-low break cannot retrigger.
  - When armed and rx_s=0: go to START with tick=0.
- START: at tick = OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - If 1: false start. Return to IDLE with no output and no flags.
  - If 0: tick=0, bit=0, go to DATA.
- DATA: sample at tick = OVERSAMPLE-1, which is mid-bit, then tick=0.
  - Shift the sample into the shift register in the direction set by LSB_FIRST.
  - After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: sample at tick = OVERSAMPLE-1.
  - Error if the XOR of the data bits and the parity bit != PARITY_ODD.
- STOP: sample STOP_BITS times, each at tick = OVERSAMPLE-1.
  - Any 0 sample sets the pending frame error.
  - The cycle after the last stop sample, deliver the word and go to IDLE.
- Delivery (one cycle after the last stop sample):
  - If data_valid=0, or data_valid & data_ready in that same cycle: load data_out, frame_err and parity_err, and set data_valid=1.
  - Otherwise: the new frame is discarded, data_out and its flags are unchanged, and overrun=1.
- Handshake:
  - data_valid stays high until a cycle with data_ready=1.
  - On acceptance with no simultaneous delivery: data_valid=0 next cycle. frame_err and parity_err clear with it.
  - overrun clears on acceptance, but not if an overrun event occurs in the same cycle.
  - data_ready while data_valid=0 has no effect.
- Frames with frame_err or parity_err are still delivered (data_valid=1) so the consumer sees the status.
- busy = (state != IDLE).
- reset_n asserted mid-frame: immediate return to reset values; the partial frame is lost.
- Each frame, including the first stop bit, is at least 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods long. Back-to-back frames are received without loss if each word is accepted before the next frame completes.

Test Plan:
- Defaults; send start, bits 1,1,1,0,0,0,0,1 (LSB first), stop; data_ready=0 -> data_valid=1, data_out=8'h87, frame_err=0, parity_err=0; raise data_ready -> data_valid=0 next cycle.
- rx_in low for OVERSAMPLE/4 cycles then high -> no data_valid, busy returns 0, then a valid frame 8'hA5 is received correctly.
- PARITY_EN=1, PARITY_ODD=0; send 8'h03 with parity bit 1 -> data_out=8'h03, parity_err=1; repeat with parity bit 0 -> parity_err=0.
- Send 8'h55 with stop bit 0, holding rx_in low 3 bit periods afterwards -> frame_err=1, data_out=8'h55, no second frame until rx_in returns high and a new start occurs.
- Send 8'h11 then 8'h22 back-to-back with data_ready=0 -> data_out stays 8'h11, overrun=1; pulse data_ready -> overrun=0, data_valid=0. Then send 8'h33 with data_ready held 1 at completion -> 8'h33 loaded, overrun stays 0.
- DATA_BITS=7, LSB_FIRST=0, STOP_BITS=2; send 1,0,1,1,0,0,1 then stops; assert reset_n=0 mid-second frame -> first word 7'h59, and all outputs zero immediately on reset.
